branch_target_predictor: RTL and testbench

//  Fetch-side branch predictor feeding the branch unit's predicted_taken/npc.

---
 rtl/branch_target_predictor.sv | 138 +++++++++++++
 tb/tb_branch_target_predictor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters; optional perf counters under BTB_PERF_CNT_EN.
// Latency: prediction registered one cycle after fetch_valid_i; training lands at the same edge.
// Backpressure: none; a lookup and a feedback update are accepted every cycle.
module branch_target_predictor #(
    parameter int AWIDTH  = 32,
    parameter int ENTRIES = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              fetch_valid_i,
    input  logic [AWIDTH-1:0] fetch_pc_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic [AWIDTH-1:0] pred_npc_o,
    input  logic              fb_taken_i,
    input  logic              fb_not_taken_i,
    input  logic [AWIDTH-1:0] fb_pc_i,
    input  logic [AWIDTH-1:0] fb_target_i,
`ifdef BTB_PERF_CNT_EN
    output logic [31:0]       cnt_lookups_o,
    output logic [31:0]       cnt_hits_o,
    output logic [31:0]       cnt_allocs_o,
`endif
    input  logic              invalidate_i
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = AWIDTH - IDX_BITS;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [AWIDTH-1:0]   tgt_q [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];

    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [AWIDTH-1:0]   pred_npc_q, pred_npc_d;

    logic [IDX_BITS-1:0] lk_idx, fb_idx;
    logic [TAG_BITS-1:0] lk_tag, fb_tag;
    logic                lk_hit, lk_taken, fb_hit;
    logic                alloc, train_inc, train_dec;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    assign lk_idx   = fetch_pc_i[IDX_BITS-1:0];
    assign lk_tag   = fetch_pc_i[AWIDTH-1:IDX_BITS];
    assign fb_idx   = fb_pc_i[IDX_BITS-1:0];
    assign fb_tag   = fb_pc_i[AWIDTH-1:IDX_BITS];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];
    assign fb_hit   = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);

    // Invalidate suppresses training; fb_taken wins if both feedback strobes are set.
    assign alloc     = !invalidate_i && fb_taken_i && !fb_hit;
    assign train_inc = !invalidate_i && fb_taken_i && fb_hit;
    assign train_dec = !invalidate_i && !fb_taken_i && fb_not_taken_i && fb_hit;

    always_comb begin
        pred_valid_d = fetch_valid_i;
        pred_taken_d = fetch_valid_i && lk_taken;
        pred_npc_d   = pred_npc_q;
        if (fetch_valid_i) begin
            pred_npc_d = lk_taken ? tgt_q[lk_idx] : fetch_pc_i + AWIDTH'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (invalidate_i) begin
            valid_d = '0;
        end else if (alloc) begin
            valid_d[fb_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q      <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_npc_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_npc_q   <= pred_npc_d;
        end
    end

    // Payload is only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            tag_q[fb_idx] <= fb_tag;
            tgt_q[fb_idx] <= fb_target_i;
            ctr_q[fb_idx] <= 2'b10;
        end else if (train_inc) begin
            tgt_q[fb_idx] <= fb_target_i;
            ctr_q[fb_idx] <= sat_inc(ctr_q[fb_idx]);
        end else if (train_dec) begin
            ctr_q[fb_idx] <= sat_dec(ctr_q[fb_idx]);
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_npc_o   = pred_npc_q;

`ifdef BTB_PERF_CNT_EN
    logic [31:0] cnt_lookups_q, cnt_hits_q, cnt_allocs_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_lookups_q <= '0;
            cnt_hits_q    <= '0;
            cnt_allocs_q  <= '0;
        end else begin
            cnt_lookups_q <= cnt_lookups_q + {31'd0, fetch_valid_i};
            cnt_hits_q    <= cnt_hits_q + {31'd0, fetch_valid_i && lk_hit};
            cnt_allocs_q  <= cnt_allocs_q + {31'd0, alloc};
        end
    end

    assign cnt_lookups_o = cnt_lookups_q;
    assign cnt_hits_o    = cnt_hits_q;
    assign cnt_allocs_o  = cnt_allocs_q;
`endif

    a_fb_exclusive: assert property (@(posedge clk_i) disable iff (reset_i)
        !(fb_taken_i && fb_not_taken_i));

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized and directed bench for branch_target_predictor against a table-level model.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_npc;
    logic        fb_taken, fb_not_taken;
    logic [31:0] fb_pc, fb_target;
    logic        invalidate;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] cnt_lookups, cnt_hits, cnt_allocs;
`endif

    int total = 0;
    int bad   = 0;

    // Model: one slot per index, counter as an integer clamped to 0..3.
    bit          m_valid [16];
    logic [27:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_npc;

    logic        exp_v, exp_t;
    logic [31:0] exp_npc;

    always #5 clk = ~clk;

    branch_target_predictor #(.AWIDTH(32), .ENTRIES(16)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .fetch_valid_i  (fetch_valid),
        .fetch_pc_i     (fetch_pc),
        .pred_valid_o   (pred_valid),
        .pred_taken_o   (pred_taken),
        .pred_npc_o     (pred_npc),
        .fb_taken_i     (fb_taken),
        .fb_not_taken_i (fb_not_taken),
        .fb_pc_i        (fb_pc),
        .fb_target_i    (fb_target),
`ifdef BTB_PERF_CNT_EN
        .cnt_lookups_o  (cnt_lookups),
        .cnt_hits_o     (cnt_hits),
        .cnt_allocs_o   (cnt_allocs),
`endif
        .invalidate_i   (invalidate)
    );

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_npc = 32'h0;
    endtask

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[pc % 16] && (m_tag[pc % 16] == pc / 16);
    endfunction

    // Drives one cycle, predicts the outcome from pre-edge model state, then advances the model.
    task automatic cycle(input bit fv, input logic [31:0] fpc, input bit ft, input bit fnt,
                         input logic [31:0] fbpc, input logic [31:0] fbt, input bit inv);
        int i;
        fetch_valid = fv; fetch_pc = fpc; fb_taken = ft; fb_not_taken = fnt;
        fb_pc = fbpc; fb_target = fbt; invalidate = inv;
        exp_v = fv;
        exp_t = fv && model_hit(fpc) && (m_ctr[fpc % 16] >= 2);
        if (fv) m_npc = exp_t ? m_tgt[fpc % 16] : fpc + 32'd1;
        exp_npc = m_npc;
        i = fbpc % 16;
        if (inv) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
        end else if (ft) begin
            if (model_hit(fbpc)) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = fbt;
            end else begin
                m_valid[i] = 1'b1; m_tag[i] = fbpc / 16; m_tgt[i] = fbt; m_ctr[i] = 2;
            end
        end else if (fnt && model_hit(fbpc)) begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic flush();
        cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h40; fb_taken = 1'b0;
        fb_not_taken = 1'b0; fb_pc = 0; fb_target = 0; invalidate = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pred_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pred_valid); end
        total++;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
        total++;
        if (pred_npc !== 32'h0) begin bad++; $display("FAIL reset_npc: got %h want 0", pred_npc); end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_npc !== 32'h41) begin
            bad++; $display("FAIL basic_miss: got v=%b t=%b npc=%h want v=1 t=0 npc=41", pred_valid, pred_taken, pred_npc);
        end
        cycle(0, 0, 1, 0, 32'h40, 32'h100, 0);
        total++;
        if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_npc !== 32'h41) begin
            bad++; $display("FAIL basic_idle_hold: got v=%b t=%b npc=%h want v=0 t=0 npc=41", pred_valid, pred_taken, pred_npc);
        end
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b1 || pred_npc !== 32'h100) begin
            bad++; $display("FAIL basic_hit: got t=%b npc=%h want t=1 npc=100", pred_taken, pred_npc);
        end
    endtask

    task automatic test_counter();
        cycle(0, 0, 0, 1, 32'h40, 0, 0);
        cycle(0, 0, 0, 1, 32'h40, 0, 0);
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b0 || pred_npc !== 32'h41) begin
            bad++; $display("FAIL ctr_weak_nt: got t=%b npc=%h want t=0 npc=41", pred_taken, pred_npc);
        end
        cycle(0, 0, 0, 1, 32'h40, 0, 0);
        cycle(0, 0, 1, 0, 32'h40, 32'h100, 0);
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b0 || pred_npc !== 32'h41) begin
            bad++; $display("FAIL ctr_sat_low: got t=%b npc=%h want t=0 npc=41", pred_taken, pred_npc);
        end
        repeat (4) cycle(0, 0, 1, 0, 32'h40, 32'h180, 0);
        cycle(0, 0, 0, 1, 32'h40, 0, 0);
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b1 || pred_npc !== 32'h180) begin
            bad++; $display("FAIL ctr_sat_high: got t=%b npc=%h want t=1 npc=180", pred_taken, pred_npc);
        end
    endtask

    task automatic test_alias();
        flush();
        cycle(0, 0, 1, 0, 32'h40, 32'h100, 0);
        cycle(0, 0, 1, 0, 32'h50, 32'h200, 0);
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b0 || pred_npc !== 32'h41) begin
            bad++; $display("FAIL alias_evicted: got t=%b npc=%h want t=0 npc=41", pred_taken, pred_npc);
        end
        cycle(1, 32'h50, 0, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b1 || pred_npc !== 32'h200) begin
            bad++; $display("FAIL alias_new: got t=%b npc=%h want t=1 npc=200", pred_taken, pred_npc);
        end
    endtask

    task automatic test_back_to_back();
        flush();
        cycle(1, 32'h40, 1, 0, 32'h40, 32'h300, 0);
        total++;
        if (pred_taken !== 1'b0 || pred_npc !== 32'h41) begin
            bad++; $display("FAIL rbw_old: got t=%b npc=%h want t=0 npc=41", pred_taken, pred_npc);
        end
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b1 || pred_npc !== 32'h300) begin
            bad++; $display("FAIL rbw_new: got t=%b npc=%h want t=1 npc=300", pred_taken, pred_npc);
        end
    endtask

    task automatic test_invalidate_wrap();
        cycle(1, 32'h40, 1, 0, 32'h40, 32'h500, 1);
        total++;
        if (pred_taken !== 1'b1 || pred_npc !== 32'h300) begin
            bad++; $display("FAIL inv_same_cycle_lookup: got t=%b npc=%h want t=1 npc=300", pred_taken, pred_npc);
        end
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b0 || pred_npc !== 32'h41) begin
            bad++; $display("FAIL inv_overrides: got t=%b npc=%h want t=0 npc=41", pred_taken, pred_npc);
        end
        cycle(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        total++;
        if (pred_valid !== 1'b1 || pred_npc !== 32'h0) begin
            bad++; $display("FAIL npc_wrap: got v=%b npc=%h want v=1 npc=0", pred_valid, pred_npc);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 1, 0, 32'h40, 32'h700, 0);
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_valid !== 1'b1 || pred_npc !== 32'h700) begin
            bad++; $display("FAIL pre_reset_hit: got v=%b npc=%h want v=1 npc=700", pred_valid, pred_npc);
        end
        reset = 1'b1;
        #1;
        total++;
        if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_npc !== 32'h0) begin
            bad++; $display("FAIL reset_async: got v=%b t=%b npc=%h want 0/0/0", pred_valid, pred_taken, pred_npc);
        end
        @(posedge clk); #1;
        total++;
        if (pred_valid !== 1'b0) begin bad++; $display("FAIL reset_hold: got v=%b want 0", pred_valid); end
        reset = 1'b0;
        model_clear();
        cycle(1, 32'h40, 0, 0, 0, 0, 0);
        total++;
        if (pred_taken !== 1'b0 || pred_npc !== 32'h41) begin
            bad++; $display("FAIL reset_clears_btb: got t=%b npc=%h want t=0 npc=41", pred_taken, pred_npc);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] fpc, fbpc;
            int          kind;
            fpc  = {28'($urandom_range(0, 2)), 4'($urandom_range(0, 3))};
            fbpc = {28'($urandom_range(0, 2)), 4'($urandom_range(0, 3))};
            if ($urandom_range(0, 30) == 0) fpc = 32'hFFFF_FFFF;
            kind = $urandom_range(0, 3);
            cycle($urandom_range(0, 3) != 0, fpc, kind == 1, kind == 2, fbpc,
                  $urandom, $urandom_range(0, 40) == 0);
            total++;
            if (pred_valid !== exp_v || pred_taken !== exp_t || pred_npc !== exp_npc) begin
                bad++;
                $display("FAIL random[%0d]: got v=%b t=%b npc=%h want v=%b t=%b npc=%h",
                         n, pred_valid, pred_taken, pred_npc, exp_v, exp_t, exp_npc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_counter();
        test_alias();
        test_back_to_back();
        test_invalidate_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
